// File: rtl/band_level_meter_pkg.sv
// Shared visualizer types: Q15 scaling, bar level type and strobe edge states.
// Used by the band meters and the filter-side strobe logic.
package viz_pkg;

  localparam int Q_FP = 15;
  localparam logic [31:0] FIX1 = 32'd1 << Q_FP;

  localparam int LEVEL_W = 4;
  typedef logic [LEVEL_W-1:0] level_t;
  localparam level_t LMAX = '1;

  typedef enum logic {
    S_IDLE,
    S_NEXT
  } edge_t;

endpackage

// File: rtl/band_level_meter_if.sv
// Sample-in / meter-out bundle between one EQ band and its level meter.
// master = band/visualizer side, slave = meter.
interface band_level_meter_if;
  import viz_pkg::*;

  logic        i_next;
  logic [31:0] i_data;
  logic        i_clr;
  level_t      o_level;
  level_t      o_peak;
  logic        o_clip;
  logic        o_valid;

  modport master (
    output i_next, i_data, i_clr,
    input  o_level, o_peak, o_clip, o_valid
  );

  modport slave (
    input  i_next, i_data, i_clr,
    output o_level, o_peak, o_clip, o_valid
  );

endinterface

// File: rtl/band_level_meter_quant.sv
// Log2 bar quantizer: leading-one position of a window peak,
// shifted so 2^Q_FP lands on level 15, clamped to LMAX.
module level_quant #(
  parameter int Q_FP = viz_pkg::Q_FP
) (
  input  logic [31:0]     mag,
  output viz_pkg::level_t level
);
  import viz_pkg::*;

  localparam int OFF = Q_FP - 15;
  localparam logic [31:0] FLOOR = 32'd1 << (Q_FP - 14);

  int msb;
  int sh;

  always_comb begin
    msb = 0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = i;
    end
    sh = msb - OFF;
    level = '0;
    if (mag >= FLOOR) begin
      if (sh > int'(LMAX)) level = LMAX;
      else                 level = level_t'(sh);
    end
  end

endmodule

// File: rtl/band_level_meter.sv
// Per-band level meter: windowed |x| peak, log2 bar, peak-hold with decay
// and clip flag, captured on the falling edge of the shared sample strobe.
module band_level_meter #(
  parameter int Q_FP     = viz_pkg::Q_FP,
  parameter int WIN_LOG2 = 9,
  parameter int HOLD_WIN = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  band_level_meter_if.slave bus
);
  import viz_pkg::*;

  localparam int HW = $clog2(HOLD_WIN + 1);
  localparam logic [31:0] ONE = 32'd1 << Q_FP;

  edge_t         state;
  logic          cap;
  logic [31:0]   mag;

  logic          s1_v;
  logic [31:0]   abs_r;
  logic          clip_r;

  logic [WIN_LOG2-1:0] cnt;
  logic [31:0]   win_max;
  logic [31:0]   max_n;
  logic          clip_acc;

  logic          s2_v;
  logic [31:0]   snap_r;
  logic          snap_clip;

  level_t        lvl;
  level_t        level_r;
  level_t        peak;
  logic [HW-1:0] hold;
  logic          clip_o;
  logic          valid_o;

  assign cap = (state == S_NEXT) && !bus.i_next;

  always_comb begin
    mag = bus.i_data;
    if (bus.i_data[31]) begin
      if (bus.i_data == 32'h8000_0000) mag = 32'h7FFF_FFFF;
      else                             mag = -bus.i_data;
    end
  end

  assign max_n = (abs_r > win_max) ? abs_r : win_max;

  // Strobe edge tracking ignores i_clr on purpose.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (bus.i_next)  state <= S_NEXT;
        S_NEXT: if (!bus.i_next) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  level_quant #(.Q_FP(Q_FP)) u_quant (
    .mag   (snap_r),
    .level (lvl)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_clr) begin
      s1_v      <= 1'b0;
      abs_r     <= '0;
      clip_r    <= 1'b0;
      cnt       <= '0;
      win_max   <= '0;
      clip_acc  <= 1'b0;
      s2_v      <= 1'b0;
      snap_r    <= '0;
      snap_clip <= 1'b0;
      level_r   <= '0;
      peak      <= '0;
      hold      <= '0;
      clip_o    <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      s1_v <= cap;
      if (cap) begin
        abs_r  <= mag;
        clip_r <= (mag >= ONE);
      end

      s2_v <= 1'b0;
      if (s1_v) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          snap_r    <= max_n;
          snap_clip <= clip_acc | clip_r;
          s2_v      <= 1'b1;
          win_max   <= '0;
          clip_acc  <= 1'b0;
        end else begin
          win_max  <= max_n;
          clip_acc <= clip_acc | clip_r;
        end
      end

      valid_o <= s2_v;
      if (s2_v) begin
        level_r <= lvl;
        clip_o  <= snap_clip;
        // peak > lvl in the decay branch, so peak-1 cannot wrap
        if (lvl >= peak) begin
          peak <= lvl;
          hold <= HW'(HOLD_WIN);
        end else if (hold != '0) begin
          hold <= hold - 1'b1;
        end else if (peak - level_t'(1) > lvl) begin
          peak <= peak - level_t'(1);
        end else begin
          peak <= lvl;
        end
      end
    end
  end

  assign bus.o_level = level_r;
  assign bus.o_peak  = peak;
  assign bus.o_clip  = clip_o;
  assign bus.o_valid = valid_o;

endmodule
